// File: rtl/boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : boot_loader
// Brief    : Streams a length-prefixed image into instruction BRAM, then runs
//            the core until it signals done and reports the run length.
// Revision : 1.0 - initial release
// ============================================================================

module boot_loader #(
    parameter int WIDTH      = 32,
    parameter int IMEM_DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    input  logic             core_done,
    output logic             core_rst,
    output logic [3:0]       im_we,
    output logic [WIDTH-1:0] im_addr,
    output logic [WIDTH-1:0] im_wdata,
    output logic [2:0]       state,
    output logic [31:0]      run_cycles,
    output logic             load_err
);

    typedef enum logic [2:0] {
        c_ST_LEN  = 3'd0,
        c_ST_LOAD = 3'd1,
        c_ST_RUN  = 3'd2,
        c_ST_HALT = 3'd3,
        c_ST_ERR  = 3'd4
    } state_t;

    localparam logic [31:0] c_DEPTH = 32'(IMEM_DEPTH);
    localparam logic [31:0] c_SAT   = 32'hFFFF_FFFF;

    state_t           r_state_q,    w_state_d;
    logic [1:0]       r_byte_cnt_q, w_byte_cnt_d;
    logic [23:0]      r_asm_q,      w_asm_d;
    logic [31:0]      r_len_q,      w_len_d;
    logic [WIDTH-1:0] r_word_idx_q, w_word_idx_d;
    logic             r_core_rst_q, w_core_rst_d;
    logic [3:0]       r_im_we_q,    w_im_we_d;
    logic [WIDTH-1:0] r_im_addr_q,  w_im_addr_d;
    logic [WIDTH-1:0] r_im_wdata_q, w_im_wdata_d;
    logic [31:0]      r_run_q,      w_run_d;
    logic             r_err_q,      w_err_d;

    logic             w_accept;
    logic             w_running;
    logic [31:0]      w_word;

    assign rx_ready  = (r_state_q == c_ST_LEN) || (r_state_q == c_ST_LOAD) ||
                       (r_state_q == c_ST_HALT);
    assign w_accept  = rx_valid && rx_ready;
    assign w_running = (r_state_q == c_ST_RUN) && !r_core_rst_q;
    // Bytes shift in from the top, so after three bytes r_asm_q = {b2, b1, b0}
    assign w_word    = {rx_data, r_asm_q};

    always_comb begin
        w_state_d    = r_state_q;
        w_byte_cnt_d = r_byte_cnt_q;
        w_asm_d      = r_asm_q;
        w_len_d      = r_len_q;
        w_word_idx_d = r_word_idx_q;
        w_im_we_d    = 4'h0;
        w_im_addr_d  = r_im_addr_q;
        w_im_wdata_d = r_im_wdata_q;
        w_run_d      = r_run_q;
        w_err_d      = r_err_q;

        case (r_state_q)
            c_ST_LEN, c_ST_LOAD: begin
                if (w_accept) begin
                    w_byte_cnt_d = r_byte_cnt_q + 2'd1;
                    if (r_byte_cnt_q != 2'd3) begin
                        w_asm_d = {rx_data, r_asm_q[23:8]};
                    end else if (r_state_q == c_ST_LEN) begin
                        if ((w_word == 32'd0) || (w_word > c_DEPTH)) begin
                            w_state_d = c_ST_ERR;
                            w_err_d   = 1'b1;
                        end else begin
                            w_state_d    = c_ST_LOAD;
                            w_len_d      = w_word;
                            w_word_idx_d = '0;
                        end
                    end else begin
                        w_im_we_d    = 4'hF;
                        w_im_addr_d  = {r_word_idx_q[WIDTH-3:0], 2'b00};
                        w_im_wdata_d = WIDTH'(w_word);
                        w_word_idx_d = r_word_idx_q + 1'b1;
                        if (32'(r_word_idx_q) == (r_len_q - 32'd1)) begin
                            w_state_d = c_ST_RUN;
                            w_run_d   = 32'd0;
                        end
                    end
                end
            end
            c_ST_RUN: begin
                if (w_running) begin
                    if (r_run_q != c_SAT) begin
                        w_run_d = r_run_q + 32'd1;
                    end
                    if (core_done) begin
                        w_state_d = c_ST_HALT;
                    end
                end
            end
            c_ST_HALT: begin
                // A byte arriving here is length byte 0 of the next image
                if (w_accept) begin
                    w_asm_d      = {rx_data, r_asm_q[23:8]};
                    w_byte_cnt_d = 2'd1;
                    w_state_d    = c_ST_LEN;
                end
            end
            c_ST_ERR: begin
                w_state_d = c_ST_ERR;
            end
            default: begin
                w_state_d = c_ST_LEN;
            end
        endcase

        // Release lags RUN entry by one edge so the final BRAM write lands first
        w_core_rst_d = !((r_state_q == c_ST_RUN) && (w_state_d == c_ST_RUN));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q    <= c_ST_LEN;
            r_byte_cnt_q <= 2'd0;
            r_asm_q      <= 24'd0;
            r_len_q      <= 32'd0;
            r_word_idx_q <= '0;
            r_core_rst_q <= 1'b1;
            r_im_we_q    <= 4'h0;
            r_im_addr_q  <= '0;
            r_im_wdata_q <= '0;
            r_run_q      <= 32'd0;
            r_err_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_byte_cnt_q <= w_byte_cnt_d;
            r_asm_q      <= w_asm_d;
            r_len_q      <= w_len_d;
            r_word_idx_q <= w_word_idx_d;
            r_core_rst_q <= w_core_rst_d;
            r_im_we_q    <= w_im_we_d;
            r_im_addr_q  <= w_im_addr_d;
            r_im_wdata_q <= w_im_wdata_d;
            r_run_q      <= w_run_d;
            r_err_q      <= w_err_d;
        end
    end

    assign core_rst   = r_core_rst_q;
    assign im_we      = r_im_we_q;
    assign im_addr    = r_im_addr_q;
    assign im_wdata   = r_im_wdata_q;
    assign state      = r_state_q;
    assign run_cycles = r_run_q;
    assign load_err   = r_err_q;

endmodule

`default_nettype wire
